sadc_ctrl: RTL and testbench
============================

Name: sadc_ctrl

Overview:
- Successive-approximation controller and channel scheduler for the 8-bit signed SAR ADC model.
- Scans a mask of analog-mux channels. Per channel it issues a track/hold pulse, then runs a binary search: it drives the DAC trial code and reads the comparator.
- Each converted code goes out through a one-entry valid/ready result register.
- Sits between the analog front end (mux, T/H, DAC, comparator) and the digital consumer.

Parameters:
NBITS, 8, conversion width; result and DAC code are signed two's complement
NCH, 4, number of analog-mux channels
SETTLE, 1, extra DAC settle cycles before each comparator sample (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin a scan of enabled channels
cont  in  1  1 = restart scan automatically when it completes
ch_en  in  NCH  channel enable mask, latched at scan start
busy  out  1  scan in progress
ch_sel  out  max(1,clog2(NCH))  analog mux select
sample  out  1  track/hold strobe, one cycle per conversion
dac_code  out  NBITS  signed DAC trial level
cmp_in  in  1  comparator: 1 = analog input >= DAC level
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  NBITS  signed conversion result
res_ch  out  max(1,clog2(NCH))  channel of res_data

Behaviour:
- Reset: state IDLE, busy=0, ch_sel=0, sample=0, dac_code=0, res_valid=0, res_data=0, res_ch=0, scan mask=0.
  - A reset asserted mid-conversion abandons the conversion with no result; the pending result is dropped.
- Internal offset-binary register u. dac_code = u XOR (1<<(NBITS-1)) at all times; reset u=1<<(NBITS-1).
- IDLE:
  - start=1 with ch_en!=0: latch mask=ch_en, ch_sel=lowest set bit, busy=1 next cycle, go SAMPLE.
  - start with ch_en==0: ignored.
  - start while busy: ignored.
- SAMPLE (1 cycle): sample=1. On exit, u=1<<(NBITS-1), so dac_code=0 (mid-scale); bit index k=NBITS-1; go TRIAL.
- TRIAL:
  - Each bit occupies SETTLE+1 cycles. cmp_in is sampled at the edge ending the last cycle.
  - If cmp_in=0, clear u[k].
  - If k>0, set u[k-1] on the same edge, decrement k, stay in TRIAL.
  - If k==0, go STORE.
- STORE:
  - If !res_valid or res_ready this cycle: res_data=u XOR MSB, res_ch=ch_sel, res_valid=1, then advance.
  - Otherwise hold in STORE (backpressure, no data loss).
  - Advance means: next set mask bit above ch_sel → ch_sel=that channel, go SAMPLE.
  - If none, and cont=1 (sampled at this edge): ch_sel=lowest mask bit, go SAMPLE.
  - Otherwise go IDLE, busy=0.
- Result handshake: res_valid falls on the edge where res_valid&&res_ready unless STORE loads a new result on that same edge. res_data/res_ch are stable while res_valid&&!res_ready. res_ready without res_valid is ignored.
- Latency: start edge to res_valid = 1 (IDLE→SAMPLE) + 1 (SAMPLE) + NBITS*(SETTLE+1) + 1 cycles. This is 19 cycles for defaults with no backpressure. Per-channel throughput is 18 cycles.
- Boundaries:
  - ch_en changes during a scan take effect at the next scan only.
  - cont deasserted mid-scan: the scan finishes, then IDLE.
  - Single-channel mask with cont=1 reconverts the same channel back-to-back.
  - Full-scale outputs are +2^(NBITS-1)-1 (comparator always 1) and -2^(NBITS-1) (always 0).
  - ch_sel changes only on the edge entering SAMPLE.

Test Plan:
- Bench comparator model cmp_in = (target >= dac_code), mask 0001, target 76 → one result 76 on ch 0; res_valid 19 cycles after start; dac_code trial sequence 0, 64, 96, 80, 72, 76, 78, 77.
- Targets -76, 127, -128, 0 on successive single scans → results -76, 127, -128, 0.
- Mask 1010, per-channel targets ch1=50, ch3=-20, cont=0 → results (ch1,50) then (ch3,-20); busy falls after second STORE; sample pulses exactly twice.
- res_ready held 0 for 40 cycles with cont=1, mask 0011 → FSM holds in STORE after the second conversion; first result stays stable; releasing ready delivers results in order with none lost.
- start while busy, and start with ch_en=0 → no extra scan; busy and sample are unaffected.
- rst asserted in TRIAL bit 4 → next cycle all outputs at reset values, no res_valid; a new start converts correctly.

Source files
------------

// File: rtl/sadc_ctrl.sv
// SAR ADC controller: scans enabled mux channels, runs a binary search per channel
// against the comparator and hands each code to a one-entry valid/ready result register.
module sadc_ctrl #(
  parameter int NBITS  = 8,
  parameter int NCH    = 4,
  parameter int SETTLE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              cont,
  input  logic [NCH-1:0]                    ch_en,
  output logic                              busy,
  output logic [$clog2(NCH>1?NCH:2)-1:0]    ch_sel,
  output logic                              sample,
  output logic signed [NBITS-1:0]           dac_code,
  input  logic                              cmp_in,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic signed [NBITS-1:0]           res_data,
  output logic [$clog2(NCH>1?NCH:2)-1:0]    res_ch
);
  localparam int CW = $clog2(NCH > 1 ? NCH : 2);
  localparam int KW = $clog2(NBITS > 1 ? NBITS : 2);
  localparam int SW = $clog2(SETTLE > 0 ? SETTLE + 1 : 2);
  localparam logic [NBITS-1:0] MSB      = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [SW-1:0]    SETTLE_L = SW'(SETTLE);
  localparam logic [KW-1:0]    KTOP     = KW'(NBITS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_TRIAL  = 2'd2;
  localparam logic [1:0] S_STORE  = 2'd3;

  logic [1:0]       state;
  logic [NCH-1:0]   mask;
  logic [NBITS-1:0] u;
  logic [KW-1:0]    k;
  logic [SW-1:0]    cnt;
  logic             bit_done;
  logic             load;
  logic             nxt_found;
  logic [CW-1:0]    nxt_ch;

  function automatic logic [CW-1:0] lowest_ch(input logic [NCH-1:0] m);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = CW'(i);
  endfunction

  // Next enabled channel strictly above the current one (descending scan keeps the lowest).
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(ch_sel))) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(i);
      end
    end
  end

  assign bit_done = (cnt == SETTLE_L);
  assign load     = !res_valid || res_ready;
  assign busy     = (state != S_IDLE);
  assign sample   = (state == S_SAMPLE);
  assign dac_code = u ^ MSB;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mask   <= '0;
      ch_sel <= '0;
      u      <= MSB;
      k      <= KTOP;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (ch_en != '0)) begin
            mask   <= ch_en;
            ch_sel <= lowest_ch(ch_en);
            state  <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          u     <= MSB;
          k     <= KTOP;
          cnt   <= '0;
          state <= S_TRIAL;
        end
        S_TRIAL: begin
          if (bit_done) begin
            cnt <= '0;
            if (!cmp_in) u[k] <= 1'b0;
            if (k != '0) begin
              u[k - 1'b1] <= 1'b1;
              k           <= k - 1'b1;
            end else begin
              state <= S_STORE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STORE: begin
          // Stall here while the result register is still occupied.
          if (load) begin
            if (nxt_found) begin
              ch_sel <= nxt_ch;
              state  <= S_SAMPLE;
            end else if (cont) begin
              ch_sel <= lowest_ch(mask);
              state  <= S_SAMPLE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
    end else if ((state == S_STORE) && load) begin
      res_valid <= 1'b1;
      res_data  <= u ^ MSB;
      res_ch    <= ch_sel;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sadc_ctrl.sv
// Directed bench for sadc_ctrl: ideal comparator per channel plus a result scoreboard.
module tb_sadc_ctrl;
  logic              clk = 1'b0;
  logic              rst, start, cont, cmp_in, res_ready;
  logic [3:0]        ch_en;
  logic              busy, sample, res_valid;
  logic [1:0]        ch_sel, res_ch;
  logic signed [7:0] dac_code, res_data;

  int tgt [4];
  int n_cmp = 0, n_fail = 0;
  int n_res = 0, n_samples = 0;
  logic [3:0] mdl_mask = 4'b0;
  int last_ch = -1;
  int last_data = 0;
  int hist_ch[$], hist_d[$];
  logic stall_prev = 1'b0;
  int prev_data = 0, prev_ch = 0;

  sadc_ctrl #(.NBITS(8), .NCH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_en(ch_en),
    .busy(busy), .ch_sel(ch_sel), .sample(sample), .dac_code(dac_code),
    .cmp_in(cmp_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ch(res_ch)
  );

  always #5 clk = ~clk;

  // Ideal comparator: the selected channel's analog level against the DAC level.
  assign cmp_in = (tgt[ch_sel] >= int'(dac_code));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clamp(input int t);
    if (t > 127) return 127;
    if (t < -128) return -128;
    return t;
  endfunction

  function automatic int next_ch(input logic [3:0] m, input int last);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (last + i + 4) % 4;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // Scoreboard: every accepted result must be the next enabled channel in cyclic order
  // and equal the clamped analog level; a stalled result must hold still.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", int'(res_valid), 1);
        chk("hold_data", int'(res_data), prev_data);
        chk("hold_ch", int'(res_ch), prev_ch);
      end
      if (res_valid && res_ready) begin
        int ec;
        ec = next_ch(mdl_mask, last_ch);
        chk("res_ch", int'(res_ch), ec);
        chk("res_data", int'(res_data), clamp(tgt[ec < 0 ? 0 : ec]));
        last_ch = ec;
        last_data = int'(res_data);
        hist_ch.push_back(int'(res_ch));
        hist_d.push_back(int'(res_data));
        n_res++;
      end
      stall_prev = res_valid && !res_ready;
      prev_data  = int'(res_data);
      prev_ch    = int'(res_ch);
    end
    if (sample) n_samples++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [3:0] m);
    mdl_mask = m;
    last_ch  = -1;
    ch_en    = m;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((busy || res_valid) && c < 400) begin
      step();
      c++;
    end
    chk(nm, int'(busy | res_valid), 0);
  endtask

  task automatic wait_valid(input string nm);
    int c;
    c = 0;
    while (!res_valid && c < 100) begin
      step();
      c++;
    end
    chk(nm, int'(res_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, r0, s0;
    int dac_exp [8] = '{0, 64, 96, 80, 72, 76, 78, 77};
    int seq [4] = '{-76, 127, -128, 0};
    rst = 1'b1; start = 1'b0; cont = 1'b0; ch_en = 4'b0; res_ready = 1'b1;
    tgt = '{0, 0, 0, 0};
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_ch_sel", int'(ch_sel), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_data", int'(res_data), 0);
    chk("rst_res_ch", int'(res_ch), 0);
    rst = 1'b0;
    step();

    // Single conversion of 76: trial ladder and latency.
    tgt[0] = 76;
    s0 = n_samples;
    run_scan(4'b0001);
    cycles = 1;
    chk("t1_sample_on", int'(sample), 1);
    chk("t1_busy_on", int'(busy), 1);
    while (!res_valid && cycles < 100) begin
      step();
      cycles++;
      if (cycles == 2) chk("t1_sample_off", int'(sample), 0);
      if (cycles >= 2 && cycles <= 16 && (cycles % 2) == 0)
        chk("t1_dac_trial", int'(dac_code), dac_exp[(cycles - 2) / 2]);
    end
    chk("t1_latency", cycles, 19);
    chk("t1_data", int'(res_data), 76);
    chk("t1_ch", int'(res_ch), 0);
    chk("t1_busy_off", int'(busy), 0);
    wait_idle("t1_idle");
    chk("t1_samples", n_samples - s0, 1);

    // Signed values and full scale.
    foreach (seq[i]) begin
      tgt[0] = seq[i];
      r0 = n_res;
      run_scan(4'b0001);
      wait_idle("t2_idle");
      chk("t2_count", n_res - r0, 1);
      chk("t2_value", last_data, seq[i]);
    end
    tgt[0] = -300;
    run_scan(4'b0001);
    wait_idle("t2_idle_neg");
    chk("t2_neg_full", last_data, -128);

    // Sparse mask 1010, single pass.
    tgt[1] = 50; tgt[3] = -20;
    r0 = n_res; s0 = n_samples;
    run_scan(4'b1010);
    wait_valid("t3_first");
    chk("t3_busy_mid", int'(busy), 1);
    step();
    wait_valid("t3_second");
    chk("t3_busy_end", int'(busy), 0);
    wait_idle("t3_idle");
    chk("t3_count", n_res - r0, 2);
    chk("t3_samples", n_samples - s0, 2);
    chk("t3_ch0", hist_ch[r0], 1);
    chk("t3_d0", hist_d[r0], 50);
    chk("t3_ch1", hist_ch[r0 + 1], 3);
    chk("t3_d1", hist_d[r0 + 1], -20);

    // Backpressure with continuous scanning.
    tgt[0] = 10; tgt[1] = -33;
    res_ready = 1'b0; cont = 1'b1;
    r0 = n_res; s0 = n_samples;
    run_scan(4'b0011);
    repeat (40) step();
    chk("t4_valid", int'(res_valid), 1);
    chk("t4_data", int'(res_data), 10);
    chk("t4_ch", int'(res_ch), 0);
    chk("t4_busy", int'(busy), 1);
    chk("t4_samples", n_samples - s0, 2);
    cont = 1'b0;
    step();
    res_ready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_count", n_res - r0, 2);
    chk("t4_d0", hist_d[r0], 10);
    chk("t4_d1", hist_d[r0 + 1], -33);

    // Start while busy and start with an empty mask.
    tgt[0] = 5;
    r0 = n_res; s0 = n_samples;
    run_scan(4'b0001);
    repeat (5) step();
    ch_en = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_busy", int'(busy), 1);
    wait_idle("t5_idle");
    chk("t5_count", n_res - r0, 1);
    chk("t5_samples", n_samples - s0, 1);
    ch_en = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_empty_busy", int'(busy), 0);
    chk("t5_empty_sample", int'(sample), 0);
    repeat (25) step();
    chk("t5_empty_count", n_res - r0, 1);
    chk("t5_empty_samples", n_samples - s0, 1);

    // Reset during the bit-4 trial, then a fresh conversion.
    tgt[0] = 76;
    r0 = n_res;
    run_scan(4'b0001);
    repeat (7) step();
    rst = 1'b1;
    step();
    chk("t6_busy", int'(busy), 0);
    chk("t6_ch_sel", int'(ch_sel), 0);
    chk("t6_sample", int'(sample), 0);
    chk("t6_dac", int'(dac_code), 0);
    chk("t6_valid", int'(res_valid), 0);
    chk("t6_data", int'(res_data), 0);
    chk("t6_res_ch", int'(res_ch), 0);
    rst = 1'b0;
    repeat (25) step();
    chk("t6_no_result", n_res - r0, 0);
    tgt[2] = -99;
    run_scan(4'b0100);
    wait_idle("t6_idle");
    chk("t6_count", n_res - r0, 1);
    chk("t6_value", last_data, -99);
    chk("t6_ch", hist_ch[hist_ch.size() - 1], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
